ex_mem_result_buffer: RTL and testbench
=======================================

// Module: ex_mem_result_buffer
// PURPOSE
//  Receiving end of the execution-stage output bundle (alu_data, memory_data, overflow_flag,
//  zero_flag, control_out, compflg_out). Captures each EX result beat, buffers it in a
//  2-entry skid buffer and presents it to the memory stage with a valid/ready handshake.
//  Supports a pipeline flush and keeps a saturating count of overflowed results.
// PARAMETERS
//  DATA_W   32  width of alu/memory data paths
//  CNT_W    16  width of overflow event counter
// PORTS
//  clk             in   1        clock, all state on rising edge
//  rst_n           in   1        reset, asynchronous, active-low
//  ex_valid        in   1        EX beat present this cycle
//  ex_ready        out  1        buffer can accept a beat (registered)
//  ex_alu_data     in   DATA_W   ALU result
//  ex_memory_data  in   DATA_W   store data
//  ex_overflow     in   1        ALU overflow flag
//  ex_zero         in   1        ALU zero flag
//  ex_control      in   control_type  control bundle (common package), opaque here
//  ex_compflg      in   1        compare/branch flag
//  flush           in   1        synchronous drop of all buffered beats
//  mem_valid       out  1        head beat valid toward memory stage
//  mem_ready       in   1        memory stage accepts head beat
//  mem_alu_data    out  DATA_W   head beat fields (same meaning as ex_*)
//  mem_memory_data out  DATA_W
//  mem_overflow    out  1
//  mem_zero        out  1
//  mem_control     out  control_type
//  mem_compflg     out  1
//  ovf_count       out  CNT_W    saturating count of delivered beats with overflow=1
// BEHAVIOUR
//  - Reset (rst_n=0, async): state EMPTY; mem_valid=0; all mem_* data/flags=0; mem_control='0;
//    ex_ready=1; ovf_count=0. No beat accepted while rst_n=0.
//  - Accept = ex_valid&&ex_ready; deliver = mem_valid&&mem_ready (sampled at rising edge).
//  - States: EMPTY (no beat), ONE (head only), FULL (head+skid).
//    EMPTY: accept -> ONE (beat to head).
//    ONE: accept&&!deliver -> FULL (beat to skid); accept&&deliver -> ONE (beat to head);
//         !accept&&deliver -> EMPTY; else hold.
//    FULL: ex_ready=0 so no accept; deliver -> ONE (skid moves to head); else hold.
//  - Latency: accepted beat visible on mem_* the cycle after acceptance when EMPTY/draining.
//  - ex_ready registered: next ex_ready = !(next state == FULL). Never combinational on mem_ready.
//  - Head fields stable while mem_valid=1 and mem_ready=0; order strictly FIFO, no loss/dup.
//  - flush=1: next state EMPTY, mem_valid=0, ex_ready=1; incoming beat that cycle dropped;
//    a head beat with mem_ready=1 in the flush cycle counts as delivered (ovf_count updates),
//    everything else discarded. mem_* data may retain stale values but mem_control forced '0.
//  - ovf_count += 1 on deliver with mem_overflow=1; saturates at 2**CNT_W-1, no wrap.
//    Cleared only by reset.
//  - Reset asserted mid-transfer: all beats lost, outputs return to reset values immediately.
// STRUCTURE
//  - control_type and any bubble/NOP control constant come from common package; add
//    ex_result_t (packed struct of the six EX fields) and the state enum to common.
//  - One sub-module natural: skid_buffer_2 (generic 2-entry valid/ready buffer on ex_result_t);
//    top adds flush and ovf_count.
// TESTING
//  - Reset: rst_n=0 mid-stream -> mem_valid=0, ex_ready=1, ovf_count=0 same cycle, no beat out.
//  - Streaming: mem_ready=1, 8 back-to-back beats alu_data=1..8 -> mem_alu_data 1..8 in order,
//    1-cycle latency, ex_ready stays 1.
//  - Backpressure: mem_ready=0, send A=0xA,B=0xB -> ex_ready=0 after B, mem holds A;
//    mem_ready=1 -> A then B delivered, ex_ready back to 1.
//  - Flush: FULL with A,B, flush=1 with ex_valid carrying C, mem_ready=0 -> next cycle
//    mem_valid=0, nothing delivered, C never appears.
//  - Overflow count: CNT_W=2, deliver 5 beats with overflow=1 -> ovf_count 1,2,3,3,3;
//    beats with overflow=1 dropped by flush not counted.
//  - Flags/control pass-through: zero=1, compflg=1, control=random -> identical on mem_* side.

Source files
------------

// File: rtl/ex_mem_result_buffer_pkg.sv
// Shared types for the EX->MEM result buffer: control bundle, result beat
// struct and the occupancy state enum of the 2-entry skid buffer.
package ex_mem_result_buffer_pkg;

  localparam int RES_DATA_W = 32;
  localparam int CTRL_W     = 8;

  // Control bundle is opaque to this block; it is only carried along.
  typedef logic [CTRL_W-1:0] control_type;

  // Bubble/NOP control value presented when no beat is held.
  localparam control_type CTRL_NOP = 8'h00;

  // One EX result beat.
  typedef struct packed {
    logic [RES_DATA_W-1:0] alu_data;
    logic [RES_DATA_W-1:0] memory_data;
    logic                  overflow;
    logic                  zero;
    control_type           control;
    logic                  compflg;
  } ex_result_t;

  // Buffer occupancy: nothing, head only, head plus skid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_e;

endpackage

// File: rtl/ex_mem_result_buffer_skid.sv
// Generic 2-entry valid/ready skid buffer carrying ex_result_t beats.
// Both handshake outputs are registered; clr drops every held beat and
// zeroes the storage so the presented bundle reads as a bubble.
module ex_mem_result_buffer_skid
  import ex_mem_result_buffer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       in_valid,
  output logic       in_ready,
  input  ex_result_t in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output ex_result_t out_data
);

  buf_state_e state_r, state_n_s;
  ex_result_t head_r, head_n_s;
  ex_result_t skid_r, skid_n_s;
  logic       in_ready_r;
  logic       out_valid_r;
  logic       accept_s;
  logic       deliver_s;

  assign accept_s  = in_valid && in_ready_r;
  assign deliver_s = out_valid_r && out_ready;

  // Next-state and storage steering for the head/skid pair.
  always_comb begin
    state_n_s = state_r;
    head_n_s  = head_r;
    skid_n_s  = skid_r;
    if (clr) begin
      state_n_s = ST_EMPTY;
      head_n_s  = '0;
      skid_n_s  = '0;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            state_n_s = ST_ONE;
            head_n_s  = in_data;
          end else begin
            state_n_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (accept_s && !deliver_s) begin
            state_n_s = ST_FULL;
            skid_n_s  = in_data;
          end else if (accept_s && deliver_s) begin
            state_n_s = ST_ONE;
            head_n_s  = in_data;
          end else if (deliver_s) begin
            state_n_s = ST_EMPTY;
          end else begin
            state_n_s = ST_ONE;
          end
        end
        ST_FULL: begin
          if (deliver_s) begin
            state_n_s = ST_ONE;
            head_n_s  = skid_r;
          end else begin
            state_n_s = ST_FULL;
          end
        end
        default: begin
          state_n_s = ST_EMPTY;
        end
      endcase
    end
  end

  // State, storage and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_EMPTY;
      head_r      <= '0;
      skid_r      <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_n_s;
      head_r      <= head_n_s;
      skid_r      <= skid_n_s;
      in_ready_r  <= (state_n_s != ST_FULL);
      out_valid_r <= (state_n_s != ST_EMPTY);
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = head_r;

endmodule

// File: rtl/ex_mem_result_buffer.sv
// EX->MEM result buffer: packs the EX bundle into a beat, buffers it in a
// 2-entry skid buffer with flush, and counts delivered overflowed results.
module ex_mem_result_buffer
  import ex_mem_result_buffer_pkg::*;
#(
  parameter int DATA_W = RES_DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [DATA_W-1:0] ex_alu_data,
  input  logic [DATA_W-1:0] ex_memory_data,
  input  logic              ex_overflow,
  input  logic              ex_zero,
  input  control_type       ex_control,
  input  logic              ex_compflg,
  input  logic              flush,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] mem_alu_data,
  output logic [DATA_W-1:0] mem_memory_data,
  output logic              mem_overflow,
  output logic              mem_zero,
  output control_type       mem_control,
  output logic              mem_compflg,
  output logic [CNT_W-1:0]  ovf_count
);

  ex_result_t       in_beat_s;
  ex_result_t       head_s;
  logic             head_valid_s;
  logic             deliver_s;
  logic [CNT_W-1:0] ovf_count_r;

  // Gather the EX outputs into one beat.
  always_comb begin
    in_beat_s             = '0;
    in_beat_s.alu_data    = ex_alu_data;
    in_beat_s.memory_data = ex_memory_data;
    in_beat_s.overflow    = ex_overflow;
    in_beat_s.zero        = ex_zero;
    in_beat_s.control     = ex_control;
    in_beat_s.compflg     = ex_compflg;
  end

  ex_mem_result_buffer_skid u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (flush),
    .in_valid  (ex_valid),
    .in_ready  (ex_ready),
    .in_data   (in_beat_s),
    .out_valid (head_valid_s),
    .out_ready (mem_ready),
    .out_data  (head_s)
  );

  // A head beat taken in a flush cycle still counts as delivered.
  assign deliver_s = head_valid_s && mem_ready;

  // Saturating count of delivered beats that carried the overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_count_r <= '0;
    end else if (deliver_s && head_s.overflow && !(&ovf_count_r)) begin
      ovf_count_r <= ovf_count_r + CNT_W'(1'b1);
    end else begin
      ovf_count_r <= ovf_count_r;
    end
  end

  assign mem_valid       = head_valid_s;
  assign mem_alu_data    = head_s.alu_data;
  assign mem_memory_data = head_s.memory_data;
  assign mem_overflow    = head_s.overflow;
  assign mem_zero        = head_s.zero;
  assign mem_control     = head_s.control;
  assign mem_compflg     = head_s.compflg;
  assign ovf_count       = ovf_count_r;

endmodule

// File: tb/tb_ex_mem_result_buffer.sv
// Directed bench for ex_mem_result_buffer (CNT_W=2 to reach saturation).
module tb_ex_mem_result_buffer;
  import ex_mem_result_buffer_pkg::*;

  localparam int DW = 32;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ex_valid;
  logic          ex_ready;
  logic [DW-1:0] ex_alu_data;
  logic [DW-1:0] ex_memory_data;
  logic          ex_overflow;
  logic          ex_zero;
  control_type   ex_control;
  logic          ex_compflg;
  logic          flush;
  logic          mem_valid;
  logic          mem_ready;
  logic [DW-1:0] mem_alu_data;
  logic [DW-1:0] mem_memory_data;
  logic          mem_overflow;
  logic          mem_zero;
  control_type   mem_control;
  logic          mem_compflg;
  logic [CW-1:0] ovf_count;

  int total = 0;
  int bad   = 0;
  control_type ctl_v;

  ex_mem_result_buffer #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_alu_data(ex_alu_data), .ex_memory_data(ex_memory_data),
    .ex_overflow(ex_overflow), .ex_zero(ex_zero), .ex_control(ex_control),
    .ex_compflg(ex_compflg), .flush(flush), .mem_valid(mem_valid),
    .mem_ready(mem_ready), .mem_alu_data(mem_alu_data),
    .mem_memory_data(mem_memory_data), .mem_overflow(mem_overflow),
    .mem_zero(mem_zero), .mem_control(mem_control), .mem_compflg(mem_compflg),
    .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; outputs are then settled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic v, input logic [31:0] a, input logic ovf);
    ex_valid       = v;
    ex_alu_data    = a;
    ex_memory_data = ~a;
    ex_overflow    = ovf;
    ex_zero        = 1'b0;
    ex_control     = 8'h00;
    ex_compflg     = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; mem_ready = 1'b0;
    beat(1'b1, 32'h55, 1'b1);
    step(); step();
    // reset values, with ex_valid high during reset
    chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("rst_ex_ready", {31'd0, ex_ready}, 32'd1);
    chk("rst_ovf", {30'd0, ovf_count}, 32'd0);
    chk("rst_ctrl", {24'd0, mem_control}, 32'd0);
    chk("rst_alu", mem_alu_data, 32'd0);
    rst_n = 1'b1;
    beat(1'b0, 32'd0, 1'b0);
    step();

    // streaming 1..8 with mem_ready=1
    mem_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      beat(1'b1, i, 1'b0);
      step();
      chk("str_valid", {31'd0, mem_valid}, 32'd1);
      chk("str_alu", mem_alu_data, i);
      chk("str_mem", mem_memory_data, ~i);
      chk("str_ready", {31'd0, ex_ready}, 32'd1);
    end
    beat(1'b0, 32'd0, 1'b0);
    step();
    chk("str_drain", {31'd0, mem_valid}, 32'd0);

    // backpressure A,B
    mem_ready = 1'b0;
    beat(1'b1, 32'hA, 1'b0); step();
    chk("bp_a_alu", mem_alu_data, 32'hA);
    chk("bp_a_ready", {31'd0, ex_ready}, 32'd1);
    beat(1'b1, 32'hB, 1'b0); step();
    chk("bp_full_ready", {31'd0, ex_ready}, 32'd0);
    chk("bp_hold_a", mem_alu_data, 32'hA);
    beat(1'b1, 32'hE, 1'b0); step();
    chk("bp_hold_a2", mem_alu_data, 32'hA);
    chk("bp_full_ready2", {31'd0, ex_ready}, 32'd0);
    beat(1'b0, 32'd0, 1'b0);
    mem_ready = 1'b1; step();
    chk("bp_b_alu", mem_alu_data, 32'hB);
    chk("bp_b_valid", {31'd0, mem_valid}, 32'd1);
    chk("bp_ready_back", {31'd0, ex_ready}, 32'd1);
    step();
    chk("bp_empty", {31'd0, mem_valid}, 32'd0);

    // flush while FULL, C offered in flush cycle, overflow beats not counted
    mem_ready = 1'b0;
    beat(1'b1, 32'hA, 1'b1); ex_control = 8'h5A; step();
    beat(1'b1, 32'hB, 1'b1); ex_control = 8'h5B; step();
    chk("fl_full", {31'd0, ex_ready}, 32'd0);
    beat(1'b1, 32'hC, 1'b1); flush = 1'b1; step();
    chk("fl_valid", {31'd0, mem_valid}, 32'd0);
    chk("fl_ready", {31'd0, ex_ready}, 32'd1);
    chk("fl_ctrl", {24'd0, mem_control}, 32'd0);
    chk("fl_ovf", {30'd0, ovf_count}, 32'd0);
    flush = 1'b0; beat(1'b0, 32'd0, 1'b0); mem_ready = 1'b1;
    step();
    chk("fl_no_c", {31'd0, mem_valid}, 32'd0);
    step();
    chk("fl_no_c2", {31'd0, mem_valid}, 32'd0);
    chk("fl_ovf2", {30'd0, ovf_count}, 32'd0);

    // flags/control pass-through
    mem_ready = 1'b0;
    ctl_v = control_type'($urandom_range(1, 255));
    beat(1'b1, 32'h1234, 1'b0);
    ex_zero = 1'b1; ex_compflg = 1'b1; ex_control = ctl_v;
    step();
    chk("pt_zero", {31'd0, mem_zero}, 32'd1);
    chk("pt_cmp", {31'd0, mem_compflg}, 32'd1);
    chk("pt_ctrl", {24'd0, mem_control}, {24'd0, ctl_v});
    chk("pt_ovf", {31'd0, mem_overflow}, 32'd0);
    beat(1'b0, 32'd0, 1'b0); mem_ready = 1'b1; step();
    chk("pt_empty", {31'd0, mem_valid}, 32'd0);

    // overflow counter saturation: 5 deliveries -> 1,2,3,3,3
    for (int i = 0; i <= 5; i++) begin
      beat(i < 5, 32'h100 + i, 1'b1);
      step();
      if (i >= 1) chk("ovf_seq", {30'd0, ovf_count}, (i > 3) ? 32'd3 : i);
    end
    beat(1'b0, 32'd0, 1'b0);

    // asynchronous reset mid-transfer from FULL
    mem_ready = 1'b0;
    beat(1'b1, 32'h77, 1'b0); step();
    beat(1'b1, 32'h78, 1'b0); step();
    chk("mid_full", {31'd0, ex_ready}, 32'd0);
    #2 rst_n = 1'b0; #1;
    chk("mid_valid", {31'd0, mem_valid}, 32'd0);
    chk("mid_ready", {31'd0, ex_ready}, 32'd1);
    chk("mid_ovf", {30'd0, ovf_count}, 32'd0);
    step();
    chk("mid_no_accept", {31'd0, mem_valid}, 32'd0);
    rst_n = 1'b1; beat(1'b0, 32'd0, 1'b0); step();
    chk("mid_after", {31'd0, mem_valid}, 32'd0);

    // head with overflow delivered in flush cycle is counted
    beat(1'b1, 32'h99, 1'b1); step();
    beat(1'b0, 32'd0, 1'b0);
    flush = 1'b1; mem_ready = 1'b1; step();
    chk("fd_ovf", {30'd0, ovf_count}, 32'd1);
    chk("fd_valid", {31'd0, mem_valid}, 32'd0);
    flush = 1'b0; step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
